// File: rtl/cm_sched_pkg.sv
// Shared types and constants for the cascadable slice-counter sequencer.
package cm_sched_pkg;
  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic grant_t;
endpackage

// File: rtl/cm_slice4.sv
// One 4-bit counter slice: next-value mux plus ripple carry to the next nibble.
module cm_slice4 (
  input  logic [3:0] q,
  input  logic [3:0] d,
  input  logic       ld,
  input  logic       inc,
  input  logic       cin,
  output logic [3:0] nq,
  output logic       cout
);
  always_comb begin
    nq   = ld ? d : ((inc & cin) ? q + 4'd1 : q);
    cout = cin & inc & (q == 4'hF);
  end
endmodule

// File: rtl/cm_slice_sched.sv
// Count register, run/step/done sequencing and round-robin parallel-load arbiter
// wrapped around a chain of cm_slice4 slices.
module cm_slice_sched
  import cm_sched_pkg::*;
#(
  parameter int SLICES    = 2,
  parameter bit TERM_HOLD = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req0_valid,
  input  logic [SLICE_W*SLICES-1:0] req0_data,
  output logic                      req0_ready,
  input  logic                      req1_valid,
  input  logic [SLICE_W*SLICES-1:0] req1_data,
  output logic                      req1_ready,
  input  logic                      run,
  input  logic                      step,
  input  logic                      ci,
  output logic [SLICE_W*SLICES-1:0] count,
  output logic                      co,
  output logic                      busy,
  output logic                      done
);
  localparam int WIDTH = SLICE_W * SLICES;

  state_t            state;
  grant_t            last_grant;
  logic              load, inc, hold_term;
  logic [WIDTH-1:0]  ld_data, nxt;
  logic [SLICES:0]   carry;

  // Loads are only taken outside RUN; the previous winner yields on a tie.
  assign req0_ready = rst_n & (state != RUN) & req0_valid & (~req1_valid | (last_grant == 1'b1));
  assign req1_ready = rst_n & (state != RUN) & req1_valid & (~req0_valid | (last_grant == 1'b0));
  assign load       = req0_ready | req1_ready;
  assign ld_data    = req1_ready ? req1_data : req0_data;

  always_comb begin
    inc = 1'b0;
    case (state)
      IDLE:    inc = ~load & ~run & step;
      RUN:     inc = run;
      default: inc = 1'b0;
    endcase
  end

  assign carry[0] = ci;

  for (genvar k = 0; k < SLICES; k++) begin : g_slice
    cm_slice4 u_slice (
      .q    (count[k*SLICE_W +: SLICE_W]),
      .d    (ld_data[k*SLICE_W +: SLICE_W]),
      .ld   (load),
      .inc  (inc),
      .cin  (carry[k]),
      .nq   (nxt[k*SLICE_W +: SLICE_W]),
      .cout (carry[k+1])
    );
  end

  assign co        = carry[SLICES];
  assign hold_term = TERM_HOLD && (state == RUN) && co;
  assign busy      = (state == RUN);
  assign done      = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count      <= '0;
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      if (load) last_grant <= grant_t'(req1_ready);
      // At terminal count in hold mode the slices would wrap; keep all-ones instead.
      if (!hold_term) count <= nxt;
      case (state)
        IDLE: if (!load && run) state <= RUN;
        RUN: begin
          if (!run)           state <= IDLE;
          else if (hold_term) state <= DONE;
        end
        DONE: if (load || !run) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
